// File: rtl/cnn_layer_accel_row_read_sequencer.sv
// rtl/cnn_layer_accel_row_read_sequencer.sv - row-by-row fetch/read sequencer for the prefetch buffer
// Defining ROW_SEQ_STATS_EN builds the saturating fetch/cancel statistics counters.
module cnn_layer_accel_row_read_sequencer #(
  parameter int C_CLG2_DEPTH  = 10,
  parameter int C_PIXEL_WIDTH = 16,
  parameter int C_RD_LATENCY  = 2
) (
  input  logic                     rd_clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [C_CLG2_DEPTH-1:0]  num_rows,
  input  logic [C_CLG2_DEPTH-1:0]  num_cols,
  output logic                     row_fetch_req,
  input  logic                     row_fetched,
  input  logic                     cncl_fetch_req,
  output logic                     rd_en,
  output logic                     rst_addr,
  output logic                     next_row,
  output logic [C_CLG2_DEPTH-1:0]  input_row,
  output logic [C_CLG2_DEPTH-1:0]  input_col,
  input  logic [C_PIXEL_WIDTH-1:0] pix_in,
  input  logic                     out_stall,
  output logic [C_PIXEL_WIDTH-1:0] pix_out,
  output logic                     pix_valid,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              stat_fetch_cnt,
  output logic [15:0]              stat_cncl_cnt
);

  localparam int W = C_CLG2_DEPTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_READ,
    S_ROW_END,
    S_DRAIN
  } state_t;

  state_t                   state_q, state_d;
  logic [W-1:0]             rows_q, rows_d;
  logic [W-1:0]             cols_q, cols_d;
  logic [W-1:0]             row_q, row_d;
  logic [W-1:0]             col_q, col_d;
  logic                     req_q, req_d;
  logic                     next_row_q, next_row_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;
  logic [C_RD_LATENCY-1:0]  vld_sr_q, vld_sr_d;
  logic [C_PIXEL_WIDTH-1:0] pix_q, pix_d;
  logic                     pix_valid_q, pix_valid_d;

  // rd_en follows out_stall in the same cycle so the coordinates always match the read.
  assign rd_en = (state_q == S_READ) && !out_stall;

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    row_d       = row_q;
    col_d       = col_q;
    req_d       = 1'b0;
    next_row_d  = 1'b0;
    done_d      = 1'b0;
    vld_sr_d    = (vld_sr_q << 1) | C_RD_LATENCY'(rd_en);
    pix_valid_d = vld_sr_q[C_RD_LATENCY-1];
    pix_d       = vld_sr_q[C_RD_LATENCY-1] ? pix_in : pix_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d = num_rows;
          cols_d = num_cols;
          row_d  = '0;
          col_d  = '0;
          if (num_rows == '0 || num_cols == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (cncl_fetch_req) begin
          state_d = S_READ;
        end else begin
          req_d   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (row_fetched) begin
          state_d = S_READ;
        end else begin
          req_d = 1'b1;
        end
      end
      S_READ: begin
        if (rd_en) begin
          col_d = col_q + W'(1);
          if (col_q == cols_q - W'(1)) begin
            state_d    = S_ROW_END;
            next_row_d = 1'b1;
          end
        end
      end
      S_ROW_END: begin
        col_d = '0;
        if (row_q == rows_q - W'(1)) begin
          state_d = S_DRAIN;
        end else begin
          row_d   = row_q + W'(1);
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (vld_sr_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rows_q      <= '0;
      cols_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      req_q       <= 1'b0;
      next_row_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      vld_sr_q    <= '0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      row_q       <= row_d;
      col_q       <= col_d;
      req_q       <= req_d;
      next_row_q  <= next_row_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      vld_sr_q    <= vld_sr_d;
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign row_fetch_req = req_q;
  assign next_row      = next_row_q;
  assign rst_addr      = next_row_q;
  assign input_row     = row_q;
  assign input_col     = col_q;
  assign pix_out       = pix_q;
  assign pix_valid     = pix_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef ROW_SEQ_STATS_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] cncl_cnt_q, cncl_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    cncl_cnt_d  = cncl_cnt_q;
    if (state_q == S_IDLE && start) begin
      fetch_cnt_d = '0;
      cncl_cnt_d  = '0;
    end else begin
      if (state_q == S_WAIT && row_fetched && fetch_cnt_q != 16'hFFFF) begin
        fetch_cnt_d = fetch_cnt_q + 16'd1;
      end
      if (state_q == S_FETCH && cncl_fetch_req && cncl_cnt_q != 16'hFFFF) begin
        cncl_cnt_d = cncl_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      cncl_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      cncl_cnt_q  <= cncl_cnt_d;
    end
  end

  assign stat_fetch_cnt = fetch_cnt_q;
  assign stat_cncl_cnt  = cncl_cnt_q;
`else
  assign stat_fetch_cnt = '0;
  assign stat_cncl_cnt  = '0;
`endif

endmodule
